// File: rtl/la_capture_core.sv
// la_capture_core
//   On-chip logic-analyzer capture engine. Samples a WIDTH-bit probe bus into
//   a DEPTH-entry circular buffer, triggers on a masked level/edge condition
//   and keeps a programmable number of pre-trigger samples. Once a capture is
//   complete, the buffer is read back in logical order (0 = oldest sample).
//
// Ports
//   gclk, gresetn      sample clock, asynchronous active-low reset
//   arm, abort         start capture (IDLE/DONE only); abort to IDLE (wins)
//   probe_i            signals under observation
//   trig_mask/value    masked compare for the trigger
//   trig_mode          00 level, 01 rising, 10 falling, 11 any masked change
//   pre_count          samples retained ahead of the trigger sample
//   busy/triggered/done capture status
//   rd_en, rd_addr     read request, logical index (pre_count = trigger)
//   rd_data, rd_valid  read result, one cycle after the request
module la_capture_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             gclk,
  input  logic             gresetn,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] probe_i,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [1:0]       trig_mode,
  input  logic [AW-1:0]    pre_count,
  output logic             busy,
  output logic             triggered,
  output logic             done,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    post_left;
  logic [AW-1:0]    trig_ptr;
  logic [AW-1:0]    pre_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] value_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] prev_probe;
  logic             prev_match;
  logic             have_prev;   // a sample has been written since arm

  logic             writing;
  logic             match;
  logic             change;
  logic             hit;
  logic [AW-1:0]    post_init;
  logic [AW-1:0]    rd_phys;

  always_comb begin
    writing   = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    match     = ((probe_i ^ value_q) & mask_q) == '0;
    change    = ((probe_i ^ prev_probe) & mask_q) != '0;
    post_init = AW'(DEPTH - 1) - pre_q;
    // Oldest retained sample sits pre_q entries behind the trigger sample.
    rd_phys   = trig_ptr - pre_q + rd_addr;
    hit       = 1'b0;
    case (mode_q)
      2'b00:   hit = match;
      2'b01:   hit = have_prev && match && !prev_match;
      2'b10:   hit = have_prev && !match && prev_match;
      default: hit = have_prev && change;
    endcase
  end

  // Buffer storage carries no reset; contents are only meaningful in DONE.
  always_ff @(posedge gclk) begin
    if (writing) mem[wr_ptr] <= probe_i;
  end

  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      cnt        <= '0;
      post_left  <= '0;
      trig_ptr   <= '0;
      pre_q      <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      mode_q     <= '0;
      prev_probe <= '0;
      prev_match <= 1'b0;
      have_prev  <= 1'b0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == S_DONE && rd_en) begin
        rd_data  <= mem[rd_phys];
        rd_valid <= 1'b1;
      end

      if (writing) begin
        wr_ptr     <= wr_ptr + AW'(1);
        prev_probe <= probe_i;
        prev_match <= match;
        have_prev  <= 1'b1;
      end

      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        triggered <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm) begin
              mask_q    <= trig_mask;
              value_q   <= trig_value;
              mode_q    <= trig_mode;
              pre_q     <= pre_count;
              wr_ptr    <= '0;
              cnt       <= '0;
              have_prev <= 1'b0;
              triggered <= 1'b0;
              done      <= 1'b0;
              busy      <= 1'b1;
              state     <= (pre_count != '0) ? S_PRE : S_WAIT;
            end
          end
          S_PRE: begin
            cnt <= cnt + AW'(1);
            if (cnt + AW'(1) == pre_q) state <= S_WAIT;
          end
          S_WAIT: begin
            if (hit) begin
              trig_ptr  <= wr_ptr;
              triggered <= 1'b1;
              post_left <= post_init;
              if (post_init == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            post_left <= post_left - AW'(1);
            if (post_left == AW'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core
//   Directed bench for la_capture_core at WIDTH=8, DEPTH=16. A table of
//   capture scenarios (counting probe, various trigger setups) is applied in
//   a loop; control, edge-qualification and reset corner cases are
//   hand-written sequences.
module tb_la_capture_core;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             gclk;
  logic             gresetn;
  logic             arm;
  logic             abort;
  logic [WIDTH-1:0] probe_i;
  logic [WIDTH-1:0] trig_mask;
  logic [WIDTH-1:0] trig_value;
  logic [1:0]       trig_mode;
  logic [AW-1:0]    pre_count;
  logic             busy;
  logic             triggered;
  logic             done;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;

  la_capture_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .gclk       (gclk),
    .gresetn    (gresetn),
    .arm        (arm),
    .abort      (abort),
    .probe_i    (probe_i),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_mode  (trig_mode),
    .pre_count  (pre_count),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    logic [7:0] start;
    logic [7:0] mask;
    logic [7:0] value;
    logic [1:0] mode;
    logic [3:0] pre;
    logic [7:0] exp0;      // expected rd_addr 0; rd_addr i = exp0 + i
    int         trig_cyc;  // write number (from 1) that triggers
    int         done_cyc;  // write number after which done rises
  } vec_t;

  vec_t tbl [8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic read_one(input logic [3:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    rd_en   = 1'b1;
    tick();
    check($sformatf("rd_valid[%0d]", addr), rd_valid, 1'b1);
    check($sformatf("rd_data[%0d]", addr), rd_data, exp);
    rd_en = 1'b0;
  endtask

  task automatic arm_capture(input logic [7:0] start, input logic [7:0] mask,
                             input logic [7:0] value, input logic [1:0] mode,
                             input logic [3:0] pre);
    probe_i    = start;
    trig_mask  = mask;
    trig_value = value;
    trig_mode  = mode;
    pre_count  = pre;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    check("busy_after_arm", busy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int trig_at;
    int done_at;

    tbl[0] = '{8'h2C, 8'hFF, 8'h30, 2'b00, 4'd4,  8'h2C, 5,  16};  // level
    tbl[1] = '{8'h50, 8'hFF, 8'h80, 2'b00, 4'd4,  8'h7C, 49, 60};  // long WAIT, wraps
    tbl[2] = '{8'h10, 8'hFF, 8'h18, 2'b00, 4'd0,  8'h18, 9,  24};  // pre 0
    tbl[3] = '{8'h40, 8'hFF, 8'h4F, 2'b00, 4'd15, 8'h40, 16, 16};  // pre 15
    tbl[4] = '{8'h41, 8'h01, 8'h01, 2'b01, 4'd0,  8'h43, 3,  18};  // rising, first sample no edge
    tbl[5] = '{8'h41, 8'h01, 8'h01, 2'b00, 4'd0,  8'h41, 1,  16};  // level, same stimulus
    tbl[6] = '{8'h30, 8'h04, 8'h04, 2'b10, 4'd2,  8'h36, 9,  22};  // falling
    tbl[7] = '{8'h08, 8'h10, 8'h00, 2'b11, 4'd3,  8'h0D, 9,  21};  // any change

    gresetn    = 1'b0;
    arm        = 1'b0;
    abort      = 1'b0;
    probe_i    = '0;
    trig_mask  = '0;
    trig_value = '0;
    trig_mode  = '0;
    pre_count  = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_triggered", triggered, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    gresetn = 1'b1;
    tick();

    // arm while busy is ignored; abort mid-POST
    arm_capture(8'h00, 8'hFF, 8'hFF, 2'b00, 4'd2);
    repeat (4) tick();
    trig_value = 8'h00;
    pre_count  = 4'd0;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    check("rearm_ignored_trig", triggered, 1'b0);
    check("rearm_ignored_busy", busy, 1'b1);
    probe_i = 8'hFF;
    tick();
    check("ctl_trigger", triggered, 1'b1);
    probe_i = 8'h00;
    repeat (2) tick();
    check("ctl_post_done", done, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_triggered", triggered, 1'b0);
    check("abort_done", done, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("abort_rd_valid", rd_valid, 1'b0);

    // rising: bit0 held high across arm must not trigger until a 0->1 edge
    arm_capture(8'h01, 8'h01, 8'h01, 2'b01, 4'd2);
    repeat (10) tick();
    check("rise_hold_no_trig", triggered, 1'b0);
    probe_i = 8'h00;
    tick();
    check("rise_low_no_trig", triggered, 1'b0);
    probe_i = 8'h01;
    tick();
    check("rise_edge_trig", triggered, 1'b1);
    probe_i = 8'h05;
    done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        done_at = i;
        break;
      end
    end
    check("rise_post_len", done_at, 13);
    read_one(4'd0, 8'h01);
    read_one(4'd1, 8'h00);
    read_one(4'd2, 8'h01);
    read_one(4'd3, 8'h05);

    // table-driven captures with a counting probe
    for (int v = 0; v < 8; v++) begin
      arm_capture(tbl[v].start, tbl[v].mask, tbl[v].value, tbl[v].mode, tbl[v].pre);
      trig_at = 0;
      done_at = 0;
      for (int i = 1; i <= 100; i++) begin
        tick();
        if (triggered && trig_at == 0) trig_at = i;
        probe_i = probe_i + 8'd1;
        if (done) begin
          done_at = i;
          break;
        end
      end
      check($sformatf("v%0d_trig_cyc", v), trig_at, tbl[v].trig_cyc);
      check($sformatf("v%0d_done_cyc", v), done_at, tbl[v].done_cyc);
      check($sformatf("v%0d_busy_done", v), busy, 1'b0);
      if (done_at == 0) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end else begin
        for (int a = 0; a < DEPTH; a++) begin
          rd_addr = 4'(a);
          rd_en   = 1'b1;
          tick();
          check($sformatf("v%0d_rd_valid", v), rd_valid, 1'b1);
          check($sformatf("v%0d_rd_data_%0d", v, a), rd_data, tbl[v].exp0 + 8'(a));
        end
        rd_en = 1'b0;
        tick();
        check($sformatf("v%0d_rd_valid_drop", v), rd_valid, 1'b0);
      end
    end

    // asynchronous reset in the middle of POST
    arm_capture(8'h2C, 8'hFF, 8'h30, 2'b00, 4'd4);
    for (int i = 0; i < 7; i++) begin
      tick();
      probe_i = probe_i + 8'd1;
    end
    check("pre_reset_triggered", triggered, 1'b1);
    #2;
    gresetn = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_triggered", triggered, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_rd_valid", rd_valid, 1'b0);
    check("async_rst_rd_data", rd_data, 8'h00);
    tick();
    gresetn = 1'b1;
    tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_rst_rd_valid", rd_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/la_capture_core.md
# la_capture_core

Parametrised on-chip logic-analyzer capture engine: samples a WIDTH-bit probe bus into a DEPTH-entry circular buffer, triggers on a masked value/edge condition, and retains a programmable number of pre-trigger samples. It is the next generation of our embedded debug capture, replacing a fixed six-signal, single-trigger analyzer with configurable width, depth, trigger mode and pre-trigger position. Captured data are read back through a simple synchronous read port by the debug/readout logic.

## Interface
- WIDTH, 8, probe/sample width in bits (1..64)
- DEPTH, 256, buffer entries; power of two, 4..4096
- AW, log2(DEPTH), derived address width; not to be overridden
- gclk  in  1  sample/system clock
- gresetn  in  1  reset; asynchronous and active-low
- arm  in  1  start capture pulse; honoured only in IDLE or DONE
- abort  in  1  return to IDLE from any state; wins over arm
- probe_i  in  WIDTH  signals under observation
- trig_mask  in  WIDTH  1 = bit participates in trigger compare
- trig_value  in  WIDTH  compare value for masked bits
- trig_mode  in  2  00 level, 01 rising, 10 falling, 11 any change of masked bits
- pre_count  in  AW  samples kept before trigger sample (0..DEPTH-1)
- busy  out  1  capture in progress (PRE, WAIT, POST)
- triggered  out  1  trigger seen in current capture
- done  out  1  buffer complete and readable
- rd_en  in  1  read request
- rd_addr  in  AW  logical index; 0 = oldest sample, pre_count = trigger sample
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data valid

## Operation
- States: IDLE, PRE, WAIT, POST, DONE. Reset: IDLE; busy, triggered, done, rd_valid, rd_data, write pointer, counters all 0.
- arm in IDLE/DONE: latch trig_mask, trig_value, trig_mode, pre_count; wr_ptr<=0, cnt<=0, triggered<=0, done<=0; next state PRE if pre_count>0, else WAIT. arm in PRE/WAIT/POST ignored.
- Every cycle in PRE/WAIT/POST: mem[wr_ptr]<=probe_i, wr_ptr<=wr_ptr+1 (mod DEPTH).
- PRE: cnt counts writes; after pre_count writes go WAIT. Trigger not evaluated in PRE.
- match = ((probe_i ^ trig_value) & trig_mask) == 0. prev_match/prev_probe register the previous written sample.
- WAIT hit: level = match; rising = match & !prev_match; falling = !match & prev_match; any-change = ((probe_i ^ prev_probe) & trig_mask) != 0. Edge modes require at least one earlier sample written since arm; first sample after arm never edge-hits.
- On hit: that sample is written, trig_ptr<=wr_ptr, triggered<=1, post_left<=DEPTH-1-pre_count; if post_left is 0 go DONE, else POST.
- POST: decrement post_left per write; after last write go DONE, done<=1.
- WAIT wraps indefinitely; oldest samples overwritten. Total stored = exactly DEPTH samples.
- start_ptr = trig_ptr - pre_count (mod DEPTH). Read physical address = start_ptr + rd_addr (mod DEPTH).
- Reads honoured only in DONE; rd_en elsewhere: rd_valid stays 0, rd_data holds.
- abort in any state: next state IDLE, busy/triggered/done<=0; buffer contents undefined. abort with arm same cycle: IDLE.
- pre_count/trigger inputs changed mid-capture have no effect (latched copies used).

## Timing
- arm at edge n: busy=1 after edge n; first sample written at edge n+1.
- Trigger sample present on probe_i at edge k (WAIT): written and triggered=1 after edge k.
- Last write at edge k+DEPTH-1-pre_count; done=1, busy=0 after that same edge.
- Read: rd_en at edge r -> rd_data/rd_valid after edge r (1-cycle latency); rd_valid is a 1-cycle pulse per request; back-to-back reads sustain one per cycle.
- abort at edge a: busy=0 after edge a.

## Test plan
- Reset: assert gresetn=0 mid-POST -> busy, triggered, done, rd_valid, rd_data all 0 immediately; IDLE after release.
- Level, WIDTH=8 DEPTH=16: probe counts +1/cycle, mask 0xFF, value 0x30, pre_count 4 -> done; rd_addr 0..15 return 0x2C..0x3B, rd_addr 4 = 0x30.
- Wrap: same but value 0x80 reached after >40 WAIT cycles -> rd_addr 0..15 = 0x7C..0x8B, in order.
- Rising: bit0 held 1 across arm, mask 0x01 value 0x01 mode 01 -> no trigger until bit0 0->1; mode 00 same stimulus triggers on first WAIT sample.
- Boundaries: pre_count 0 -> rd_addr 0 = trigger sample; pre_count 15 -> done same edge as trigger, rd_addr 15 = trigger sample.
- Control: arm while busy ignored (no restart); abort mid-POST -> busy 0 next cycle, done 0, rd_en gives rd_valid 0; re-arm captures normally.
